pcie_clkrst_rate_ctl: RTL and testbench
=======================================

# pcie_clkrst_rate_ctl

Sequencer for the PCIe clock/reset divider. It accepts rate-change requests and waits for the consumers of the divided enable to go quiescent. It then programs the new division factor, issues the divider's `sync` pulse, confirms the first post-sync `out_en`, and acknowledges the requester. It sits in the clkrst subsystem and drives `div_factor`/`sync` of the clock-enable divider.

## Interface
Parameters:
- `TP`, 0: propagation delay applied to all register assignments.
- `INIT_RATE`, 0: rate code loaded at reset (0..6).
- `QUIESCE_CYCLES`, 8: consecutive `idle_in` cycles required before applying a change (≥1).
- `ALIGN_TIMEOUT`, 128: ALIGN-state cycles allowed before reporting failure (≥2).

Ports:
- `in_clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `rate_req`  in  1  request, level; held until `rate_ack` or `rate_err`.
- `rate_sel`  in  3  requested rate code r; factor = 1<<r (1..64); code 7 is invalid.
- `idle_in`  in  1  datapath quiescent indication.
- `out_en`  in  1  enable returned from the divider.
- `div_factor`  out  7  factor to divider, registered.
- `sync`  out  1  one-cycle divider realignment pulse.
- `cur_rate`  out  3  currently applied rate code.
- `busy`  out  1  high whenever state ≠ IDLE.
- `rate_ack`  out  1  one-cycle completion pulse.
- `rate_err`  out  1  one-cycle failure pulse.

## Operation
- States: IDLE, DRAIN, APPLY, SYNC, ALIGN, DONE, ERR. All outputs decode from registers; no input-to-output combinational path.
- IDLE: samples `rate_req`; `rate_sel` is latched on acceptance.
  - Code 7 → ERR.
  - Code == `cur_rate` → DONE, with no sync.
  - Otherwise → DRAIN.
- DRAIN: a shared counter increments while `idle_in`=1 and clears when `idle_in`=0. On reaching QUIESCE_CYCLES → APPLY. There is no timeout.
- APPLY: loads `div_factor` <= 1<<r and `cur_rate` <= r → SYNC.
- SYNC: `sync`=1 for exactly this cycle → ALIGN.
- ALIGN:
  - The first cycle is blanking; `out_en` is ignored.
  - From the second cycle on, `out_en`=1 → DONE.
  - If the counter reaches ALIGN_TIMEOUT first → ERR. The new rate stays applied.
- DONE: `rate_ack`=1 → IDLE.
- ERR: `rate_err`=1 → IDLE.
- `rate_req` is ignored in every state except IDLE. The requester drops `rate_req` in the ack/err cycle; if it is still high in the following IDLE cycle, that is a new request.
- Counter width: $clog2(max(QUIESCE_CYCLES, ALIGN_TIMEOUT))+1. The counter clears on every state entry.
- Reset values (also apply when `rst` is asserted mid-operation):
  - state IDLE;
  - `div_factor` = 1<<INIT_RATE;
  - `cur_rate` = INIT_RATE;
  - `sync`, `busy`, `rate_ack`, `rate_err` = 0;
  - no ack or err is issued for an aborted request.

## Timing
- Request accepted in IDLE at cycle T0. With `idle_in` held high:
  - DRAIN T1..T_Q;
  - APPLY T_Q+1;
  - SYNC T_Q+2, with the new `div_factor` visible in the same cycle;
  - ALIGN from T_Q+3;
  - against a compliant divider, `out_en` is high at T_Q+4 for every factor, so DONE (`rate_ack`) is at T_Q+5.
- Same-rate or invalid request: `rate_ack` or `rate_err` at T1.
- `busy` is high from T1 through the ack/err cycle inclusive.
- ALIGN timeout: ERR at (ALIGN entry) + ALIGN_TIMEOUT.

## Structure
- Shared package `pcie_clkrst_pkg` holds:
  - state enum (3 bits);
  - RATE_W=3 and RATE_INVALID=3'd7;
  - DIV_W=7;
  - function rate_to_factor(r).
- No sub-module: a single FSM with one shared counter.
- The bench instantiates `pcie_clkrst_rate_ctl` alongside the divider, with `sync`/`div_factor` to the divider and the divider's `out_en` back to this block.

## Test plan
- Reset: `rst`=1 for 2 cycles with INIT_RATE=0 → `div_factor`=1, `cur_rate`=0, and `sync`/`busy`/`rate_ack`/`rate_err`=0.
- `rate_sel`=3, `idle_in`=1, Q=8, accept at T0 → `sync` only at T10 with `div_factor`=8, `rate_ack` at T13, `cur_rate`=3, `busy` T1..T13.
- Same as the previous case, but `idle_in`=0 for 3 cycles starting T4 → counter restarts; `sync` moves to T16 and `rate_ack` to T19.
- `rate_sel`=7 → `rate_err` at T1, no `sync`, `div_factor` unchanged. `rate_sel`==`cur_rate` → `rate_ack` at T1, no `sync`.
- `out_en` forced 0 after `sync`, ALIGN_TIMEOUT=128 → `rate_err` 128 cycles after ALIGN entry, new `div_factor` retained, no `rate_ack`.
- `rst` pulsed during DRAIN and, separately, during ALIGN → IDLE next cycle, `div_factor`=1<<INIT_RATE, no `rate_ack`/`rate_err`. A subsequent request completes normally.

Source files
------------

// File: rtl/pcie_clkrst_pkg.sv
// Shared types and constants for the PCIe clock/reset rate sequencer.
// Rate codes map to power-of-two divider factors.
`timescale 1ns/1ps
package pcie_clkrst_pkg;

    localparam int RATE_W = 3;
    localparam int DIV_W  = 7;

    localparam logic [RATE_W-1:0] RATE_INVALID = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_APPLY = 3'd2,
        ST_SYNC  = 3'd3,
        ST_ALIGN = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    function automatic logic [DIV_W-1:0] rate_to_factor(
        input logic [RATE_W-1:0] r
    );
        rate_to_factor = DIV_W'(1) << r;
    endfunction

endpackage

// File: rtl/pcie_clkrst_rate_ctl.sv
// Rate-change sequencer: drain, program divider, sync, confirm alignment.
// One FSM with a single counter shared by DRAIN and ALIGN.
`timescale 1ns/1ps
module pcie_clkrst_rate_ctl
    import pcie_clkrst_pkg::*;
#(
    parameter int TP             = 0,
    parameter int INIT_RATE      = 0,
    parameter int QUIESCE_CYCLES = 8,
    parameter int ALIGN_TIMEOUT  = 128
) (
    input  logic              in_clk,
    input  logic              rst,
    input  logic              rate_req,
    input  logic [RATE_W-1:0] rate_sel,
    input  logic              idle_in,
    input  logic              out_en,
    output logic [DIV_W-1:0]  div_factor,
    output logic              sync,
    output logic [RATE_W-1:0] cur_rate,
    output logic              busy,
    output logic              rate_ack,
    output logic              rate_err
);

    localparam int CNT_MAX = (QUIESCE_CYCLES > ALIGN_TIMEOUT) ?
                             QUIESCE_CYCLES : ALIGN_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [RATE_W-1:0] RST_RATE = RATE_W'(INIT_RATE);
    localparam logic [CNT_W-1:0]  Q_LAST   = CNT_W'(QUIESCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  A_LAST   = CNT_W'(ALIGN_TIMEOUT - 1);

    // Reject illegal parameter sets at elaboration; register timing is
    // zero-delay in this synthesizable view, so TP must not be negative.
    if (INIT_RATE < 0 || INIT_RATE > 6 || QUIESCE_CYCLES < 1 ||
        ALIGN_TIMEOUT < 2 || TP < 0) begin : g_bad_param
        $error("pcie_clkrst_rate_ctl: illegal parameter value");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [RATE_W-1:0]   r_sel;
    logic [RATE_W-1:0]   r_rate;
    logic [DIV_W-1:0]    r_div;

    // State register
    always_ff @(posedge in_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; requests are only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (rate_req) begin
                    if (rate_sel == RATE_INVALID) begin
                        w_state_nxt = ST_ERR;
                    end else if (rate_sel == r_rate) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (idle_in && r_cnt == Q_LAST) begin
                    w_state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: w_state_nxt = ST_SYNC;
            ST_SYNC:  w_state_nxt = ST_ALIGN;
            ST_ALIGN: begin
                // first ALIGN cycle (count 0) is blanking
                if (r_cnt != '0 && out_en) begin
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == A_LAST) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            ST_ERR:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Shared counter: cleared on every state change, counts in DRAIN/ALIGN
    always_ff @(posedge in_clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_state == ST_DRAIN) begin
            r_cnt <= idle_in ? r_cnt + 1'b1 : '0;
        end else if (r_state == ST_ALIGN) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Latch the requested code and program the divider in APPLY
    always_ff @(posedge in_clk) begin
        if (rst) begin
            r_sel  <= RST_RATE;
            r_rate <= RST_RATE;
            r_div  <= rate_to_factor(RST_RATE);
        end else begin
            if (r_state == ST_IDLE && rate_req) begin
                r_sel <= rate_sel;
            end
            if (r_state == ST_APPLY) begin
                r_rate <= r_sel;
                r_div  <= rate_to_factor(r_sel);
            end
        end
    end

    // Outputs decode purely from registered state
    always_comb begin
        sync       = (r_state == ST_SYNC);
        busy       = (r_state != ST_IDLE);
        rate_ack   = (r_state == ST_DONE);
        rate_err   = (r_state == ST_ERR);
        div_factor = r_div;
        cur_rate   = r_rate;
    end

endmodule

// File: tb/tb_pcie_clkrst_rate_ctl.sv
// Bench for pcie_clkrst_rate_ctl with a behavioural clock-enable divider.
// Stimulus queues expected sync/ack/err events; a monitor checks them.
`timescale 1ns/1ps
module tb_pcie_clkrst_rate_ctl;
    import pcie_clkrst_pkg::*;

    localparam int Q    = 8;
    localparam int AT   = 128;
    localparam int INIT = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rate_req = 1'b0;
    logic [2:0]  rate_sel = 3'd0;
    logic        idle_in = 1'b1;
    logic        force_low = 1'b0;
    logic        out_en;
    logic        out_en_div;
    logic [6:0]  dcnt;
    logic [6:0]  div_factor;
    logic        sync;
    logic [2:0]  cur_rate;
    logic        busy;
    logic        rate_ack;
    logic        rate_err;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int t0 = 0;

    typedef struct {
        int kind;
        int t;
        int f;
        int r;
    } ev_t;

    ev_t exp_q[$];

    pcie_clkrst_rate_ctl #(
        .TP(0),
        .INIT_RATE(INIT),
        .QUIESCE_CYCLES(Q),
        .ALIGN_TIMEOUT(AT)
    ) dut (
        .in_clk(clk),
        .rst(rst),
        .rate_req(rate_req),
        .rate_sel(rate_sel),
        .idle_in(idle_in),
        .out_en(out_en),
        .div_factor(div_factor),
        .sync(sync),
        .cur_rate(cur_rate),
        .busy(busy),
        .rate_ack(rate_ack),
        .rate_err(rate_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // divider: sync restarts the count; out_en is high two cycles later
    always @(posedge clk) begin
        if (rst) begin
            dcnt <= '0;
            out_en_div <= 1'b0;
        end else begin
            out_en_div <= (dcnt == 7'd0);
            if (sync || dcnt >= div_factor - 7'd1)
                dcnt <= '0;
            else
                dcnt <= dcnt + 7'd1;
        end
    end

    assign out_en = out_en_div & ~force_low;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    // monitor: every sync/ack/err must match the head of the queue
    always @(negedge clk) begin
        int k;
        ev_t e;
        if (!rst && (sync || rate_ack || rate_err)) begin
            k = sync ? 0 : (rate_ack ? 1 : 2);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", k, -1);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", k, e.kind);
                chk("event_cycle", cyc, e.t);
                chk("div_factor", int'(div_factor), e.f);
                chk("cur_rate", int'(cur_rate), e.r);
                chk("busy_at_event", int'(busy), 1);
            end
        end
    end

    task automatic tick_to(int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [2:0] sel);
        @(posedge clk);
        #1;
        rate_sel = sel;
        rate_req = 1'b1;
        t0 = cyc;
    endtask

    task automatic push(int k, int dt, int f, int r);
        ev_t e;
        e.kind = k;
        e.t = t0 + dt;
        e.f = f;
        e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_end(int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (rate_ack || rate_err) begin
                seen = 1'b1;
                rate_req = 1'b0;
            end
        end
        rate_req = 1'b0;
        chk("end_seen", int'(seen), 1);
        @(negedge clk);
        chk("busy_after_end", int'(busy), 0);
    endtask

    task automatic chk_rst_state(string tag);
        chk({tag, "_div"}, int'(div_factor), 1 << INIT);
        chk({tag, "_rate"}, int'(cur_rate), INIT);
        chk({tag, "_sync"}, int'(sync), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ack"}, int'(rate_ack), 0);
        chk({tag, "_err"}, int'(rate_err), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_rst_state("reset");

        // 1 -> 8: sync T10, ack T13
        issue(3'd3);
        push(0, 10, 8, 3);
        push(1, 13, 8, 3);
        @(negedge clk);
        chk("busy_T0", int'(busy), 0);
        @(negedge clk);
        chk("busy_T1", int'(busy), 1);
        wait_end(40);

        // 8 -> 32 with idle dropped T4..T6: sync T16, ack T19
        issue(3'd5);
        push(0, 16, 32, 5);
        push(1, 19, 32, 5);
        tick_to(t0 + 4);
        idle_in = 1'b0;
        tick_to(t0 + 7);
        idle_in = 1'b1;
        wait_end(40);

        // invalid code: err at T1, divider untouched
        issue(3'd7);
        push(2, 1, 32, 5);
        wait_end(10);

        // same rate: ack at T1, no sync
        issue(3'd5);
        push(1, 1, 32, 5);
        wait_end(10);

        // align timeout: ALIGN entry T11, err at T11+AT, rate kept
        force_low = 1'b1;
        issue(3'd1);
        push(0, 10, 2, 1);
        push(2, 11 + AT, 2, 1);
        wait_end(200);
        force_low = 1'b0;

        // reset during DRAIN
        issue(3'd2);
        tick_to(t0 + 4);
        rst = 1'b1;
        rate_req = 1'b0;
        tick_to(t0 + 5);
        rst = 1'b0;
        @(negedge clk);
        chk_rst_state("rst_drain");
        repeat (20) @(negedge clk);

        // reset during ALIGN (sync already issued)
        issue(3'd4);
        push(0, 10, 16, 4);
        tick_to(t0 + 11);
        rst = 1'b1;
        rate_req = 1'b0;
        tick_to(t0 + 12);
        rst = 1'b0;
        @(negedge clk);
        chk_rst_state("rst_align");
        repeat (20) @(negedge clk);

        // normal request after resets, largest factor
        issue(3'd6);
        push(0, 10, 64, 6);
        push(1, 13, 64, 6);
        wait_end(40);

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
